// File: rtl/mult_unit_e.sv
// rtl/mult_unit_e.sv - radix-2 shift-add 32x32 multiplier for the execute stage
// Signed operands are reduced to magnitudes at capture and the product is negated on the last iteration.
module mult_unit_e (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start_multE,
  input  logic        mult_signE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        ReadHiLoE,
  output logic [31:0] HiE,
  output logic [31:0] LoE,
  output logic        mult_busyE,
  output logic        mult_doneE,
  output logic        StallMultE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_mcand;
  logic [63:0] r_acc;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_neg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_start;
  logic        w_last;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_sum;
  logic [63:0] w_result;

  assign w_start  = start_multE && (r_state != S_BUSY);
  assign w_last   = (r_state == S_BUSY) && (r_cnt == 5'd31);
  assign w_mag_a  = (mult_signE && SrcAE[31]) ? (~SrcAE + 32'd1) : SrcAE;
  assign w_mag_b  = (mult_signE && SrcBE[31]) ? (~SrcBE + 32'd1) : SrcBE;
  assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
  assign w_result = r_neg ? (~w_sum + 64'd1) : w_sum;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_multE) w_next = S_BUSY;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start_multE ? S_BUSY : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mult_busyE = 1'b0;
    mult_doneE = 1'b0;
    StallMultE = 1'b0;
    case (r_state)
      S_BUSY: begin
        mult_busyE = 1'b1;
        StallMultE = start_multE | ReadHiLoE;
      end
      S_DONE:  mult_doneE = 1'b1;
      default: ;
    endcase
  end

  // HI/LO only move on the final iteration, so an abandoned multiply never leaks a partial sum
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_acc    <= 64'd0;
      r_cnt    <= 5'd0;
      r_neg    <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else if (w_start) begin
      r_mcand  <= {32'd0, w_mag_a};
      r_mplier <= w_mag_b;
      r_acc    <= 64'd0;
      r_cnt    <= 5'd0;
      r_neg    <= mult_signE & (SrcAE[31] ^ SrcBE[31]);
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_sum;
      r_mcand  <= {r_mcand[62:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[31:1]};
      r_cnt    <= r_cnt + 5'd1;
      if (w_last) begin
        r_hi <= w_result[63:32];
        r_lo <= w_result[31:0];
      end
    end
  end

  assign HiE = r_hi;
  assign LoE = r_lo;

endmodule

// File: tb/tb_mult_unit_e.sv
// tb/tb_mult_unit_e.sv - directed self-checking bench for mult_unit_e
// Operands are scrambled while busy to show they are only sampled at capture.
module tb_mult_unit_e;

  logic        CLK;
  logic        reset;
  logic        start_multE;
  logic        mult_signE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        ReadHiLoE;
  logic [31:0] HiE;
  logic [31:0] LoE;
  logic        mult_busyE;
  logic        mult_doneE;
  logic        StallMultE;

  int n_asserts = 0;
  int n_fail    = 0;

  mult_unit_e dut (
    .CLK        (CLK),
    .reset      (reset),
    .start_multE(start_multE),
    .mult_signE (mult_signE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .ReadHiLoE  (ReadHiLoE),
    .HiE        (HiE),
    .LoE        (LoE),
    .mult_busyE (mult_busyE),
    .mult_doneE (mult_doneE),
    .StallMultE (StallMultE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is positioned at a falling edge; start is presented immediately.
  task automatic mult_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input bit inj, input string tag);
    logic [63:0] prev;
    int bad;
    prev        = {HiE, LoE};
    SrcAE       = a;
    SrcBE       = b;
    mult_signE  = s;
    start_multE = 1'b1;
    ReadHiLoE   = 1'b0;
    #1 chk({tag, ":stall_at_start"}, StallMultE, 0);
    @(posedge CLK);
    @(negedge CLK);
    start_multE = 1'b0;
    chk({tag, ":busy_first"}, mult_busyE, 1);
    chk({tag, ":done_first"}, mult_doneE, 0);
    bad = 0;
    for (int i = 1; i <= 31; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!mult_busyE || mult_doneE || ({HiE, LoE} !== prev)) bad++;
      SrcAE      = $urandom;
      SrcBE      = $urandom;
      mult_signE = 1'($urandom_range(0, 1));
      if (inj && i == 5) begin
        start_multE = 1'b1;
        #1 chk({tag, ":stall_on_start"}, StallMultE, 1);
      end
      if (inj && i == 6) begin
        start_multE = 1'b0;
        ReadHiLoE   = 1'b1;
        #1 chk({tag, ":stall_on_readhilo"}, StallMultE, 1);
      end
      if (inj && i == 7) begin
        ReadHiLoE = 1'b0;
        #1 chk({tag, ":stall_quiet"}, StallMultE, 0);
      end
    end
    chk({tag, ":busy_window_bad_cycles"}, 64'(bad), 0);
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, ":done"}, mult_doneE, 1);
    chk({tag, ":busy_in_done"}, mult_busyE, 0);
    chk({tag, ":product"}, {HiE, LoE}, exp);
  endtask

  task automatic idle_gap(input logic [63:0] exp, input string tag);
    start_multE = 1'b0;
    ReadHiLoE   = 1'b1;
    @(negedge CLK);
    chk({tag, ":idle_flags"}, {mult_busyE, mult_doneE, StallMultE}, 0);
    chk({tag, ":held"}, {HiE, LoE}, exp);
    ReadHiLoE = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    start_multE = 1'b0;
    mult_signE  = 1'b0;
    SrcAE       = 32'd0;
    SrcBE       = 32'd0;
    ReadHiLoE   = 1'b0;
    #1;
    chk("rst:hilo", {HiE, LoE}, 0);
    chk("rst:flags", {mult_busyE, mult_doneE, StallMultE}, 0);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);

    mult_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 1'b0, "u_ffxff");
    idle_gap(64'hFFFFFFFE_00000001, "u_ffxff");
    mult_op(32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFEB, 1'b0, "s_m3x7");
    idle_gap(64'hFFFFFFFF_FFFFFFEB, "s_m3x7");
    mult_op(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 1'b0, "s_minxmin");
    idle_gap(64'h40000000_00000000, "s_minxmin");
    mult_op(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000, 1'b0, "s_minx1");
    idle_gap(64'hFFFFFFFF_80000000, "s_minx1");
    mult_op(32'h80000000, 32'h00000001, 1'b0, 64'h00000000_80000000, 1'b0, "u_minx1");
    idle_gap(64'h00000000_80000000, "u_minx1");
    mult_op(32'h00010003, 32'h00000100, 1'b0, 64'h00000000_01000300, 1'b1, "stall");
    idle_gap(64'h00000000_01000300, "stall");

    SrcAE       = 32'h12345678;
    SrcBE       = 32'h00000009;
    mult_signE  = 1'b0;
    start_multE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start_multE = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    start_multE = 1'b1;
    ReadHiLoE   = 1'b1;
    reset       = 1'b1;
    #1;
    chk("midrst:hilo", {HiE, LoE}, 0);
    chk("midrst:flags", {mult_busyE, mult_doneE, StallMultE}, 0);
    @(negedge CLK);
    chk("midrst:held_in_reset", {HiE, LoE, 1'b0, mult_busyE}, 0);
    reset = 1'b0;
    mult_op(32'd6, 32'd7, 1'b0, 64'h00000000_0000002A, 1'b0, "post_rst_6x7");
    idle_gap(64'h00000000_0000002A, "post_rst_6x7");

    mult_op(32'd5, 32'd5, 1'b0, 64'h00000000_00000019, 1'b0, "b2b_5x5");
    mult_op(32'd2, 32'd3, 1'b0, 64'h00000000_00000006, 1'b0, "b2b_2x3");
    idle_gap(64'h00000000_00000006, "b2b_2x3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
